// File: rtl/libfpga_common.sv
// rtl/libfpga_common.sv - shared constant helpers for the fpga library
// Purpose: elaboration-time helpers shared across library blocks.
// Contents: clog2(v) returns the number of bits needed to index v distinct values.
package libfpga_common;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_line_stage.sv
// rtl/delay_line_stage.sv - one {vld, data} register of the programmable delay line
// Purpose: single stage holding a valid bit and W-bit data word.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   en               load d_* into the stage this cycle
//   flush            clear the valid bit next cycle (data is left alone)
//   d_vld, d_data    stage input
//   q_vld, q_data    stage contents
// Macro: DELAY_LINE_PROG_DATA_RESET_EN gives the data register an asynchronous reset;
//   without it only the valid bit is reset.
module delay_line_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         flush,
  input  logic         d_vld,
  input  logic [W-1:0] d_data,
  output logic         q_vld,
  output logic [W-1:0] q_data
);

  // Flush wins over the shift for the valid bit only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld <= 1'b0;
    end else if (flush) begin
      q_vld <= 1'b0;
    end else if (en) begin
      q_vld <= d_vld;
    end
  end

`ifdef DELAY_LINE_PROG_DATA_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_data <= '0;
    end else if (en) begin
      q_data <= d_data;
    end
  end
`else
  // Data is qualified by q_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      q_data <= d_data;
    end
  end
`endif

endmodule

// File: rtl/delay_line_prog.sv
// rtl/delay_line_prog.sv - runtime-programmable delay line for valid-qualified data
// Purpose: delays {in_vld, in_data} by dly enabled cycles (clamped to MAX_N); dly=0 is a
//   combinational passthrough. en stalls all stages, flush clears all valid bits.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   en                  advance all stages this cycle
//   flush               synchronous clear of every stage valid bit; drops the input item
//   dly [SELW]          selected delay, values above MAX_N clamp to MAX_N
//   in_vld, in_data     input item
//   out_vld, out_data   item at the selected tap
//   busy                any stage before the tap (0..dly_eff-1) holds a valid item
// Macro: DELAY_LINE_PROG_DATA_RESET_EN resets the data registers too (see delay_line_stage).
module delay_line_prog
  import libfpga_common::*;
#(
  parameter  int W     = 8,
  parameter  int MAX_N = 8,
  localparam int SELW  = clog2(MAX_N + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic [SELW-1:0] dly,
  input  logic            in_vld,
  input  logic [W-1:0]    in_data,
  output logic            out_vld,
  output logic [W-1:0]    out_data,
  output logic            busy
);

  logic [MAX_N-1:0] vld_s;
  logic [W-1:0]     data_s [MAX_N];
  logic [SELW-1:0]  dly_eff;

  for (genvar g = 0; g < MAX_N; g++) begin : g_stage
    if (g == 0) begin : g_head
      delay_line_stage #(.W(W)) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .flush  (flush),
        .d_vld  (in_vld),
        .d_data (in_data),
        .q_vld  (vld_s[g]),
        .q_data (data_s[g])
      );
    end else begin : g_body
      delay_line_stage #(.W(W)) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .flush  (flush),
        .d_vld  (vld_s[g-1]),
        .d_data (data_s[g-1]),
        .q_vld  (vld_s[g]),
        .q_data (data_s[g])
      );
    end
  end

  assign dly_eff = (dly > SELW'(MAX_N)) ? SELW'(MAX_N) : dly;

  // Tap k>=1 reads stage k-1; tap 0 is the raw input, masked by flush since that
  // item is being dropped this cycle.
  always_comb begin
    out_vld  = in_vld & ~flush;
    out_data = in_data;
    for (int i = 0; i < MAX_N; i++) begin
      if (dly_eff == SELW'(i + 1)) begin
        out_vld  = vld_s[i];
        out_data = data_s[i];
      end
    end
  end

  // Only stages up to and including the tap stage count as in flight.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      if (SELW'(i) < dly_eff) begin
        busy = busy | vld_s[i];
      end
    end
  end

endmodule

// File: tb/tb_delay_line_prog.sv
// tb/tb_delay_line_prog.sv - directed self-checking bench for delay_line_prog
module tb_delay_line_prog;

  localparam int W     = 8;
  localparam int MAX_N = 8;
  localparam int SELW  = 4;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            flush;
  logic [SELW-1:0] dly;
  logic            in_vld;
  logic [W-1:0]    in_data;
  logic            out_vld;
  logic [W-1:0]    out_data;
  logic            busy;

  int n_checks;
  int n_fail;

  delay_line_prog #(.W(W), .MAX_N(MAX_N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .flush    (flush),
    .dly      (dly),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_line();
    en = 1'b1; flush = 1'b1; in_vld = 1'b0; in_data = '0;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; dly = 4'd3; in_vld = 1'b0; in_data = '0;
    repeat (2) tick();
    settle();
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_vld: got %b want 0", out_vld);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
    end
`ifdef DELAY_LINE_PROG_DATA_RESET_EN
    n_checks++;
    if (out_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data);
    end
`endif
    #3 rst_n = 1'b1;
    tick();
  endtask

  // dly=3, push 11,22,33 on consecutive enabled cycles.
  task automatic test_basic_delay();
    logic [7:0] push_d [7];
    logic       push_v [7];
    logic       exp_v  [7];
    logic [7:0] exp_d  [7];
    logic       exp_b  [7];
    push_v = '{1, 1, 1, 0, 0, 0, 0};
    push_d = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_v  = '{0, 0, 0, 1, 1, 1, 0};
    exp_d  = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    exp_b  = '{0, 1, 1, 1, 1, 1, 0};
    clear_line();
    dly = 4'd3;
    for (int c = 0; c < 7; c++) begin
      in_vld = push_v[c]; in_data = push_d[c];
      settle();
      n_checks++;
      if (out_vld !== exp_v[c]) begin
        n_fail++; $display("FAIL basic_out_vld[%0d]: got %b want %b", c, out_vld, exp_v[c]);
      end
      if (exp_v[c]) begin
        n_checks++;
        if (out_data !== exp_d[c]) begin
          n_fail++; $display("FAIL basic_out_data[%0d]: got %h want %h", c, out_data, exp_d[c]);
        end
      end
      n_checks++;
      if (busy !== exp_b[c]) begin
        n_fail++; $display("FAIL basic_busy[%0d]: got %b want %b", c, busy, exp_b[c]);
      end
      tick();
    end
  endtask

  task automatic test_passthrough();
    clear_line();
    dly = 4'd0; in_vld = 1'b1; in_data = 8'hA5; en = 1'b0;
    settle();
    n_checks++;
    if (out_vld !== 1'b1 || out_data !== 8'hA5) begin
      n_fail++; $display("FAIL pass_out: got %b/%h want 1/a5", out_vld, out_data);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL pass_busy: got %b want 0", busy);
    end
    flush = 1'b1;
    settle();
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_fail++; $display("FAIL pass_flush_vld: got %b want 0", out_vld);
    end
    tick();
    flush = 1'b0; in_vld = 1'b0; en = 1'b1;
  endtask

  // dly=4: one enabled push, 5 stalled clocks, then 3 more enabled clocks.
  task automatic test_stall();
    clear_line();
    dly = 4'd4; en = 1'b1; in_vld = 1'b1; in_data = 8'h01;
    tick();
    in_vld = 1'b0; in_data = 8'hEE; en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_checks++;
      if (out_vld !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold_vld[%0d]: got %b want 0", c, out_vld);
      end
      tick();
    end
    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_checks++;
      if (out_vld !== 1'b0) begin
        n_fail++; $display("FAIL stall_run_vld[%0d]: got %b want 0", c, out_vld);
      end
      tick();
    end
    settle();
    n_checks++;
    if (out_vld !== 1'b1 || out_data !== 8'h01) begin
      n_fail++; $display("FAIL stall_emerge: got %b/%h want 1/01", out_vld, out_data);
    end
    tick();
  endtask

  // dly=15 clamps to 8.
  task automatic test_clamp();
    clear_line();
    dly = 4'd15; in_vld = 1'b1; in_data = 8'h5A;
    tick();
    in_vld = 1'b0; in_data = 8'h00;
    for (int c = 0; c < 7; c++) begin
      settle();
      n_checks++;
      if (out_vld !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL clamp_wait[%0d]: vld/busy got %b/%b want 0/1", c, out_vld, busy);
      end
      tick();
    end
    settle();
    n_checks++;
    if (out_vld !== 1'b1 || out_data !== 8'h5A || busy !== 1'b1) begin
      n_fail++; $display("FAIL clamp_emerge: got %b/%h/%b want 1/5a/1", out_vld, out_data, busy);
    end
    tick();
    n_checks++;
    if (out_vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL clamp_after: vld/busy got %b/%b want 0/0", out_vld, busy);
    end
  endtask

  task automatic test_flush();
    clear_line();
    dly = 4'd5;
    for (int c = 0; c < 3; c++) begin
      in_vld = 1'b1; in_data = 8'hAA + 8'(c * 17);
      tick();
    end
    settle();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_busy: got %b want 1", busy);
    end
    flush = 1'b1; in_vld = 1'b1; in_data = 8'hDD;
    tick();
    flush = 1'b0; in_vld = 1'b0; in_data = 8'h00;
    for (int c = 0; c < 8; c++) begin
      settle();
      n_checks++;
      if (out_vld !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL flush_after[%0d]: vld/busy got %b/%b want 0/0", c, out_vld, busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    clear_line();
    dly = 4'd2; in_vld = 1'b1; in_data = 8'h3C;
    tick();
    in_data = 8'h4D;
    tick();
    in_vld = 1'b0;
    settle();
    n_checks++;
    if (out_vld !== 1'b1 || out_data !== 8'h3C) begin
      n_fail++; $display("FAIL midrst_pre: got %b/%h want 1/3c", out_vld, out_data);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_now: vld/busy got %b/%b want 0/0", out_vld, busy);
    end
`ifdef DELAY_LINE_PROG_DATA_RESET_EN
    n_checks++;
    if (out_data !== 8'h00) begin
      n_fail++; $display("FAIL midrst_data: got %h want 00", out_data);
    end
`endif
    tick();
    #2 rst_n = 1'b1;
    tick();
    settle();
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after: got %b want 0", out_vld);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_delay();
    test_passthrough();
    test_stall();
    test_clamp();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
